decim_scheduler: RTL and testbench
==================================

DECIM_SCHEDULER -- requirements
Module: decim_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of audio channels sharing one FIR engine.
REQ-002 The block SHALL have parameter DEC_FACTOR, default 4: filtered samples per decimated output, per channel.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023: maximum WAIT cycles before abandoning an engine job.
REQ-004 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 Port list:
- clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous active-high reset.
- sample_in  in  NUM_CH x 16 signed  per-channel input sample.
- sample_valid_in  in  NUM_CH  per-channel single-cycle valid.
- fir_sample_out  out  16 signed  sample issued to the engine.
- fir_ch_out  out  $clog2(NUM_CH)  engine delay-line bank select.
- fir_start_out  out  1  single-cycle job start.
- fir_done_in  in  1  single-cycle job complete.
- fir_result_in  in  16 signed  engine result, valid with fir_done_in.
- dec_output  out  NUM_CH x 16 signed  decimated output per channel.
- dec_output_ready  out  NUM_CH  single-cycle output strobe per channel.
- overflow_out  out  NUM_CH  sticky dropped-sample flag.
- timeout_out  out  1  sticky engine-timeout flag.

Function
REQ-006 Each channel SHALL hold one pending register (sample plus flag), loaded on the clock edge where sample_valid_in[c] is high.
REQ-007 A valid on a channel whose flag is already set, other than in that channel's ISSUE cycle, SHALL be dropped and SHALL set overflow_out[c].
REQ-008 A valid in the same cycle the channel's pending is consumed (ISSUE) SHALL be accepted, the flag remains set, and no overflow is flagged.
REQ-009 The FSM SHALL have states IDLE, ISSUE and WAIT.
- IDLE: if any flag is set, latch the round-robin grant and go to ISSUE; otherwise stay.
- ISSUE: for one cycle, drive fir_start_out=1, fir_sample_out and fir_ch_out from the granted channel; clear its flag; go to WAIT.
- WAIT: on fir_done_in, process the result and go to IDLE; after TIMEOUT cycles without done, set timeout_out and go to IDLE.
REQ-010 Arbitration SHALL be round-robin; after a grant to channel c, channel c+1 (mod NUM_CH) has highest priority.
REQ-011 With the engine idle and one flag set, fir_start_out SHALL assert two cycles after the sample_valid_in cycle.
REQ-012 fir_done_in outside WAIT SHALL be ignored.
REQ-013 Each channel SHALL keep a decimation counter, width $clog2(DEC_FACTOR), incremented on each processed result for that channel.
REQ-014 When the counter equals DEC_FACTOR-1, on the cycle after fir_done_in:
- dec_output[c] SHALL take fir_result_in.
- dec_output_ready[c] SHALL pulse high for one cycle.
- the counter SHALL wrap to 0.
REQ-015 dec_output[c] SHALL hold its value between strobes; results are passed unmodified, with no arithmetic on the 16-bit value.
REQ-016 A timed-out job SHALL not advance that channel's counter.
REQ-017 fir_start_out SHALL be low in all states except ISSUE; at most one job is outstanding.

Reset
REQ-018 Asserting rst_in SHALL immediately:
- clear all pending flags, counters, dec_output, dec_output_ready, overflow_out, timeout_out, fir_start_out, fir_sample_out and fir_ch_out;
- set the FSM to IDLE;
- point the round-robin pointer at channel 0.
REQ-019 A fir_done_in arriving after reset mid-job SHALL be ignored (REQ-012).

Structure
REQ-020 The state enum, sample width (16) and default NUM_CH SHALL live in the shared package decim_sched_pkg.
REQ-021 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-022 Single channel: channel 0 gets 4 valids (values 100, 200, 300, 400); engine done 3 cycles after each start, echoing the sample -> four starts, fir_ch_out=0; one dec_output_ready[0] pulse with dec_output[0]=400.
REQ-023 All 4 channels valid in the same cycle -> starts in channel order 0,1,2,3; no overflow.
REQ-024 Channel 2 valid twice while the engine is stalled in WAIT -> second sample dropped, overflow_out[2]=1 and sticky until reset.
REQ-025 Channel 1 valid coincident with its ISSUE cycle -> flag remains set, second start for channel 1 follows, overflow_out[1]=0.
REQ-026 Engine never returns done, TIMEOUT=15 -> timeout_out=1 after 15 WAIT cycles; FSM returns to IDLE and serves the next pending channel.
REQ-027 rst_in asserted during WAIT, then a late fir_done_in -> all outputs 0 asynchronously; no dec_output_ready pulse.

Source files
------------

// File: rtl/decim_sched_pkg.sv
// Shared types and constants for the decimation scheduler.
package decim_sched_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/decim_scheduler_rr_arbiter.sv
// Round-robin arbiter: the channel at ptr_in has top priority, then
// ptr_in+1, and so on, wrapping at NUM_CH. Grant is one-hot with the
// matching binary index alongside.
module rr_arbiter
  import decim_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0]         req_in,
  input  logic [$clog2(NUM_CH)-1:0] ptr_in,
  output logic [NUM_CH-1:0]         grant_out,
  output logic [$clog2(NUM_CH)-1:0] grant_idx_out
);

  localparam int CH_W = $clog2(NUM_CH);

  logic            found;
  logic [CH_W-1:0] idx;

  // Walk the channels starting at the pointer; first requester wins.
  always_comb begin
    grant_out     = '0;
    grant_idx_out = '0;
    found         = 1'b0;
    idx           = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr_in) + i) % NUM_CH);
      if (!found && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        grant_idx_out  = idx;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decim_scheduler.sv
// Time-shares one FIR engine across NUM_CH channels and decimates each
// channel's filtered stream by DEC_FACTOR.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no job outstanding; grant a pending channel if any
//   ST_ISSUE | fir_start_out high for one cycle, granted flag cleared
//   ST_WAIT  | waiting for fir_done_in, bounded by the TIMEOUT down-count
module decim_scheduler
  import decim_sched_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DEC_FACTOR = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_CH*SAMPLE_W-1:0]  sample_in,
  input  logic [NUM_CH-1:0]           sample_valid_in,
  output logic signed [SAMPLE_W-1:0]  fir_sample_out,
  output logic [$clog2(NUM_CH)-1:0]   fir_ch_out,
  output logic                        fir_start_out,
  input  logic                        fir_done_in,
  input  logic signed [SAMPLE_W-1:0]  fir_result_in,
  output logic [NUM_CH*SAMPLE_W-1:0]  dec_output,
  output logic [NUM_CH-1:0]           dec_output_ready,
  output logic [NUM_CH-1:0]           overflow_out,
  output logic                        timeout_out
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEC_FACTOR);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  sched_state_e         state_q, state_d;
  logic [NUM_CH-1:0]    gnt_oh_q, gnt_oh_d;
  logic [CH_W-1:0]      gnt_idx_q, gnt_idx_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic                 start_q, start_d;
  logic [SAMPLE_W-1:0]  fir_sample_q, fir_sample_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_CH-1:0]    flag_vec;
  logic [SAMPLE_W-1:0]  pend_arr [NUM_CH];
  logic [NUM_CH-1:0]    grant_oh;
  logic [CH_W-1:0]      grant_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_in        (flag_vec),
    .ptr_in        (ptr_q),
    .grant_out     (grant_oh),
    .grant_idx_out (grant_idx)
  );

  // Per-channel pending register, overflow flag and decimation state.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                flag_q, flag_d;
    logic                ovf_q, ovf_d;
    logic                rdy_q, rdy_d;
    logic [SAMPLE_W-1:0] pend_q, pend_d;
    logic [SAMPLE_W-1:0] dec_q, dec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                issue_here;
    logic                done_here;

    assign issue_here = (state_q == ST_ISSUE) && gnt_oh_q[c];
    assign done_here  = (state_q == ST_WAIT) && fir_done_in && gnt_oh_q[c];

    // A valid landing in this channel's own ISSUE cycle refills the slot
    // being consumed, so it is accepted rather than counted as overflow.
    always_comb begin
      flag_d = flag_q;
      pend_d = pend_q;
      ovf_d  = ovf_q;
      cnt_d  = cnt_q;
      dec_d  = dec_q;
      rdy_d  = 1'b0;
      if (issue_here) begin
        flag_d = 1'b0;
      end
      if (sample_valid_in[c]) begin
        if (flag_q && !issue_here) begin
          ovf_d = 1'b1;
        end else begin
          flag_d = 1'b1;
          pend_d = sample_in[c*SAMPLE_W +: SAMPLE_W];
        end
      end
      if (done_here) begin
        if (cnt_q == CNT_W'(DEC_FACTOR - 1)) begin
          cnt_d = '0;
          dec_d = fir_result_in;
          rdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        flag_q <= 1'b0;
        ovf_q  <= 1'b0;
        rdy_q  <= 1'b0;
        pend_q <= '0;
        dec_q  <= '0;
        cnt_q  <= '0;
      end else begin
        flag_q <= flag_d;
        ovf_q  <= ovf_d;
        rdy_q  <= rdy_d;
        pend_q <= pend_d;
        dec_q  <= dec_d;
        cnt_q  <= cnt_d;
      end
    end

    assign flag_vec[c]                          = flag_q;
    assign pend_arr[c]                          = pend_q;
    assign dec_output[c*SAMPLE_W +: SAMPLE_W]   = dec_q;
    assign dec_output_ready[c]                  = rdy_q;
    assign overflow_out[c]                      = ovf_q;
  end

  // Next-state and engine-interface logic; outputs are registered so the
  // start pulse and sample line up with the ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    gnt_oh_d     = gnt_oh_q;
    gnt_idx_d    = gnt_idx_q;
    ptr_d        = ptr_q;
    start_d      = 1'b0;
    fir_sample_d = fir_sample_q;
    timer_d      = timer_q;
    tmo_d        = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (|flag_vec) begin
          gnt_oh_d     = grant_oh;
          gnt_idx_d    = grant_idx;
          ptr_d        = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
          start_d      = 1'b1;
          fir_sample_d = pend_arr[grant_idx];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = TMR_W'(TIMEOUT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fir_done_in) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      gnt_oh_q     <= '0;
      gnt_idx_q    <= '0;
      ptr_q        <= '0;
      start_q      <= 1'b0;
      fir_sample_q <= '0;
      timer_q      <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_oh_q     <= gnt_oh_d;
      gnt_idx_q    <= gnt_idx_d;
      ptr_q        <= ptr_d;
      start_q      <= start_d;
      fir_sample_q <= fir_sample_d;
      timer_q      <= timer_d;
      tmo_q        <= tmo_d;
    end
  end

  assign fir_start_out  = start_q;
  assign fir_sample_out = fir_sample_q;
  assign fir_ch_out     = gnt_idx_q;
  assign timeout_out    = tmo_q;

endmodule

// File: tb/tb_decim_scheduler.sv
// Bench for decim_scheduler: directed scenarios plus a random run, all
// checked cycle by cycle against a job-level reference model.
module tb_decim_scheduler;

  localparam int N   = 4;
  localparam int DEC = 4;
  localparam int TMO = 15;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [N*16-1:0] sample_in;
  logic [N-1:0]  sample_valid_in;
  logic [15:0]   fir_sample_out;
  logic [1:0]    fir_ch_out;
  logic          fir_start_out;
  logic          fir_done_in;
  logic [15:0]   fir_result_in;
  logic [N*16-1:0] dec_output;
  logic [N-1:0]  dec_output_ready;
  logic [N-1:0]  overflow_out;
  logic          timeout_out;

  decim_scheduler #(.NUM_CH(N), .DEC_FACTOR(DEC), .TIMEOUT(TMO)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .fir_sample_out   (fir_sample_out),
    .fir_ch_out       (fir_ch_out),
    .fir_start_out    (fir_start_out),
    .fir_done_in      (fir_done_in),
    .fir_result_in    (fir_result_in),
    .dec_output       (dec_output),
    .dec_output_ready (dec_output_ready),
    .overflow_out     (overflow_out),
    .timeout_out      (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus controls
  logic [N-1:0] drv_valid;
  logic [15:0]  drv_smp [N];
  logic         drv_done;
  logic [15:0]  drv_res;
  logic         force_done;
  bit           eng_never, echo_en, spur_en;
  int           dly_lo, dly_hi;
  int           n_start_ch [N];
  int           n_rdy_ch [N];

  // reference model: pending slots, one outstanding job, per-channel decimators
  logic [N-1:0] m_pv, m_ovf, m_rdy;
  logic [15:0]  m_ps [N];
  logic [15:0]  m_dec [N];
  int           m_cnt [N];
  int           m_ptr;
  bit           m_tmo;
  bit           m_job;
  int           m_jch, m_age, m_delay;
  logic [15:0]  m_jsmp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = '0; m_ovf = '0; m_rdy = '0; m_tmo = 0;
    m_ptr = 0; m_job = 0; m_jch = 0; m_age = 0; m_delay = 0; m_jsmp = '0;
    for (int c = 0; c < N; c++) begin
      m_ps[c] = '0; m_dec[c] = '0; m_cnt[c] = 0;
    end
  endtask

  // Advance the model across one clock edge using the inputs just driven.
  task automatic model_update();
    logic [N-1:0] op_v;
    logic [15:0]  op_s [N];
    bit issue_now, in_wait, found;
    int pick;
    op_v = m_pv;
    op_s = m_ps;
    issue_now = m_job && (m_age == 0);
    in_wait   = m_job && (m_age >= 1);
    m_rdy = '0;
    for (int c = 0; c < N; c++) begin
      if (issue_now && m_jch == c) m_pv[c] = 1'b0;
      if (drv_valid[c]) begin
        if (op_v[c] && !(issue_now && m_jch == c)) m_ovf[c] = 1'b1;
        else begin
          m_pv[c] = 1'b1;
          m_ps[c] = drv_smp[c];
        end
      end
    end
    if (!m_job) begin
      found = 0; pick = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && op_v[(m_ptr + k) % N]) begin
          found = 1; pick = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_job = 1; m_jch = pick; m_age = 0; m_jsmp = op_s[pick];
        m_ptr = (pick + 1) % N;
        m_delay = $urandom_range(dly_hi, dly_lo);
      end
    end else if (issue_now) begin
      m_age = 1;
    end else if (in_wait && drv_done) begin
      if (m_cnt[m_jch] == DEC - 1) begin
        m_cnt[m_jch] = 0;
        m_dec[m_jch] = drv_res;
        m_rdy[m_jch] = 1'b1;
      end else begin
        m_cnt[m_jch]++;
      end
      m_job = 0;
    end else if (m_age == TMO) begin
      m_tmo = 1; m_job = 0;
    end else begin
      m_age++;
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, clock, model.
  task automatic step();
    logic [N*16-1:0] exp_dec;
    logic [N*16-1:0] smp_bus;
    bit exp_start, in_wait;
    @(negedge clk_in);
    exp_start = m_job && (m_age == 0);
    for (int c = 0; c < N; c++) exp_dec[c*16 +: 16] = m_dec[c];
    chk("start", 64'(fir_start_out), 64'(exp_start));
    if (exp_start) begin
      chk("fir_ch", 64'(fir_ch_out), 64'(m_jch));
      chk("fir_sample", 64'(fir_sample_out), 64'(m_jsmp));
    end
    chk("ready", 64'(dec_output_ready), 64'(m_rdy));
    chk("dec_output", 64'(dec_output), 64'(exp_dec));
    chk("overflow", 64'(overflow_out), 64'(m_ovf));
    chk("timeout", 64'(timeout_out), 64'(m_tmo));
    for (int c = 0; c < N; c++) begin
      if (fir_start_out && int'(fir_ch_out) == c) n_start_ch[c]++;
      if (dec_output_ready[c]) n_rdy_ch[c]++;
    end
    for (int c = 0; c < N; c++) smp_bus[c*16 +: 16] = drv_smp[c];
    in_wait = m_job && (m_age >= 1);
    if (force_done) begin
      drv_done = 1'b1; drv_res = 16'($urandom);
    end else if (in_wait && !eng_never && m_age == m_delay) begin
      drv_done = 1'b1; drv_res = echo_en ? m_jsmp : 16'($urandom);
    end else if (!in_wait && spur_en && $urandom_range(7, 0) == 0) begin
      drv_done = 1'b1; drv_res = 16'($urandom);
    end else begin
      drv_done = 1'b0; drv_res = '0;
    end
    sample_in       = smp_bus;
    sample_valid_in = drv_valid;
    fir_done_in     = drv_done;
    fir_result_in   = drv_res;
    @(posedge clk_in);
    model_update();
    drv_valid  = '0;
    force_done = 1'b0;
  endtask

  task automatic zero_ports();
    sample_in = '0; sample_valid_in = '0; fir_done_in = 1'b0; fir_result_in = '0;
    drv_valid = '0; drv_done = 1'b0; drv_res = '0; force_done = 1'b0;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      n_start_ch[c] = 0; n_rdy_ch[c] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    zero_ports();
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic valid_on(input int ch, input logic [15:0] v);
    drv_valid[ch] = 1'b1;
    drv_smp[ch]   = v;
  endtask

  initial begin
    rst_in = 1'b1;
    zero_ports();
    for (int c = 0; c < N; c++) drv_smp[c] = '0;
    eng_never = 0; echo_en = 1; spur_en = 0; dly_lo = 3; dly_hi = 3;
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // single channel, four samples, engine echoes after 3 cycles
    for (int k = 1; k <= 4; k++) begin
      valid_on(0, 16'(k * 100));
      repeat (8) step();
    end
    #2;
    chk("r22_starts_ch0", 64'(n_start_ch[0]), 64'd4);
    chk("r22_rdy_pulses", 64'(n_rdy_ch[0]), 64'd1);
    chk("r22_dec0", 64'(dec_output[15:0]), 64'd400);

    // reset mid-WAIT, then a late done must be ignored
    dly_lo = 10; dly_hi = 10;
    valid_on(0, 16'h1234);
    repeat (6) step();
    @(negedge clk_in);
    zero_ports();
    #2 rst_in = 1'b1;
    #1;
    chk("r27_start", 64'(fir_start_out), 64'd0);
    chk("r27_ch", 64'(fir_ch_out), 64'd0);
    chk("r27_sample", 64'(fir_sample_out), 64'd0);
    chk("r27_dec", 64'(dec_output), 64'd0);
    chk("r27_rdy", 64'(dec_output_ready), 64'd0);
    chk("r27_ovf", 64'(overflow_out), 64'd0);
    chk("r27_tmo", 64'(timeout_out), 64'd0);
    model_reset();
    clear_counts();
    @(negedge clk_in);
    rst_in = 1'b0;
    force_done = 1'b1;
    repeat (8) step();
    #2;
    chk("r27_no_rdy", 64'(n_rdy_ch[0]), 64'd0);

    // all channels at once: served in order 0..3 from reset
    do_reset();
    clear_counts();
    dly_lo = 3; dly_hi = 3;
    for (int c = 0; c < N; c++) valid_on(c, 16'($urandom));
    step();
    repeat (30) step();
    #2;
    chk("r23_ovf", 64'(overflow_out), 64'd0);
    chk("r23_starts", 64'(n_start_ch[0] + n_start_ch[1] + n_start_ch[2] + n_start_ch[3]), 64'd4);

    // channel 2 overrun while the engine stalls
    do_reset();
    dly_lo = 12; dly_hi = 12;
    valid_on(2, 16'h0aaa);
    repeat (4) step();
    valid_on(2, 16'h0bbb);
    step();
    valid_on(2, 16'h0ccc);
    step();
    repeat (40) step();
    #2;
    chk("r24_ovf_sticky", 64'(overflow_out), 64'h4);
    do_reset();
    step();
    #2;
    chk("r24_ovf_cleared", 64'(overflow_out), 64'h0);

    // channel 1 valid in its own ISSUE cycle is accepted
    do_reset();
    clear_counts();
    dly_lo = 3; dly_hi = 3;
    valid_on(1, 16'h0111);
    step();
    step();
    valid_on(1, 16'h0222);
    step();
    repeat (20) step();
    #2;
    chk("r25_starts_ch1", 64'(n_start_ch[1]), 64'd2);
    chk("r25_ovf1", 64'(overflow_out[1]), 64'd0);

    // engine never answers: timeout, then the next pending channel is served
    do_reset();
    clear_counts();
    eng_never = 1;
    valid_on(0, 16'h7000);
    valid_on(3, 16'h7003);
    repeat (45) step();
    #2;
    chk("r26_tmo", 64'(timeout_out), 64'd1);
    chk("r26_start_ch3", 64'(n_start_ch[3]), 64'd1);
    eng_never = 0;

    // random traffic with random engine latency, some past the timeout
    do_reset();
    echo_en = 0; spur_en = 1; dly_lo = 1; dly_hi = 20;
    for (int t = 0; t < 2500; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5, 0) == 0) valid_on(c, 16'($urandom));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
